cbus_arbiter: RTL and testbench
===============================

CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of upstream CBus masters (legal 2..4).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ireqs  input  cbus_req_t[NUM_PORTS]  upstream requests (valid, is_write, size, addr, strobe, data, len, burst).
REQ-005 SHALL have port iresps  output  cbus_resp_t[NUM_PORTS]  upstream responses (ready, last, data).
REQ-006 SHALL have port oreq  output  cbus_req_t  request to the downstream RAM model.
REQ-007 SHALL have port oresp  input  cbus_resp_t  response from the downstream RAM model.

Function
REQ-008 SHALL implement two states: IDLE and BUSY, plus a registered grant index sel (width clog2(NUM_PORTS)).
REQ-009 In IDLE, oreq SHALL be all-zero and every iresps[i] SHALL be all-zero.
REQ-010 In IDLE, if any ireqs[i].valid is high at a rising edge, the block SHALL latch sel to the winner and enter BUSY on that edge.
REQ-011 In IDLE with no valid request, state and sel SHALL be unchanged.
REQ-012 In BUSY, oreq SHALL equal ireqs[sel] combinationally (zero added latency), bit-for-bit on every field.
REQ-013 In BUSY, iresps[sel] SHALL equal oresp combinationally; iresps[j] for j != sel SHALL be all-zero.
REQ-014 In BUSY, sel SHALL NOT change, regardless of other ports' valid, until the transaction completes.
REQ-015 In BUSY, a cycle with oresp.ready and oresp.last both high SHALL return the block to IDLE on the following edge.
REQ-016 A grant decision SHALL take exactly one cycle: the first cycle oreq.valid is high is the cycle after the winner's valid was sampled.
REQ-017 Between two back-to-back transactions there SHALL be at least one IDLE cycle with oreq.valid low.
REQ-018 If the granted master drops valid in BUSY before last, the block SHALL forward the dropped request unchanged and remain in BUSY; protocol checking is the downstream model's duty.
REQ-019 A losing requester SHALL see iresps all-zero (ready low) for the whole time it waits; its request is not consumed.
REQ-020 Simultaneous valid on several ports SHALL be resolved per REQ-025/REQ-026; exactly one port is granted.

Reset
REQ-021 Asserting reset SHALL immediately (asynchronously) force state to IDLE and sel to 0.
REQ-022 Reset asserted mid-BUSY SHALL abort the transaction: oreq and all iresps zero in the same cycle, no last delivered.
REQ-023 In round-robin builds, the last-granted pointer SHALL reset to NUM_PORTS-1, so port 0 has top priority first.
REQ-024 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge with reset low.

Configuration
REQ-025 With macro CBUS_ARBITER_ROUND_ROBIN_EN defined, the winner SHALL be the first valid port searching upward (with wrap) from last-granted+1; last-granted updates on each grant.
REQ-026 Without CBUS_ARBITER_ROUND_ROBIN_EN, the winner SHALL be the lowest-index valid port (fixed priority, port 0 highest); no pointer register exists.

Verification
REQ-027 Single read: port 0 valid, addr 0x8000_0000, len 3, size 3 -> oreq.valid rises one cycle later, iresps[0] gets 4 beats, last on beat 4, then one IDLE cycle.
REQ-028 Contention, fixed priority: ports 0 and 1 valid same cycle, port 0 kept valid for back-to-back requests -> port 0 granted every time, iresps[1].ready stays 0.
REQ-029 Contention, round-robin: ports 0 and 1 continuously valid, each len 0 -> grants alternate 0,1,0,1; port 1 write of data 0x233 to 0x2333_3000 with strobe 0xFF reaches oreq intact.
REQ-030 Hold stability: port 1 granted for a len 7 burst while port 0 raises valid mid-burst -> oreq fields unchanged through all 8 beats; port 0 granted only after port 1's last.
REQ-031 Reset mid-burst: assert reset on beat 2 of a len 3 read -> oreq.valid and all iresps drop in the same cycle; after release, a new port 1 request is granted normally.

Source files
------------

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: N-master CBus arbiter serving one transaction at a time with zero-latency forwarding.
// Define CBUS_ARBITER_ROUND_ROBIN_EN for round-robin grants; default build is fixed priority (port 0 highest).
package cbus_arbiter_pkg;
  localparam int unsigned CBUS_ADDR_W  = 32;
  localparam int unsigned CBUS_DATA_W  = 64;
  localparam int unsigned CBUS_STRB_W  = CBUS_DATA_W / 8;
  localparam int unsigned CBUS_LEN_W   = 8;
  localparam int unsigned CBUS_SIZE_W  = 3;
  localparam int unsigned CBUS_BURST_W = 2;

  typedef struct packed {
    logic                    valid;
    logic                    is_write;
    logic [CBUS_SIZE_W-1:0]  size;
    logic [CBUS_ADDR_W-1:0]  addr;
    logic [CBUS_STRB_W-1:0]  strobe;
    logic [CBUS_DATA_W-1:0]  data;
    logic [CBUS_LEN_W-1:0]   len;
    logic [CBUS_BURST_W-1:0] burst;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;
endpackage

module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_PORTS],
  output cbus_resp_t iresps [NUM_PORTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int unsigned SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] winner;
  logic             any_valid;

`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
  logic [SEL_W-1:0] last_grant;
  int unsigned      idx;

  // First valid port searching upward from last_grant+1, wrapping.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = (32'(last_grant) + k) % NUM_PORTS;
      if (!any_valid && ireqs[idx].valid) begin
        winner    = SEL_W'(idx);
        any_valid = 1'b1;
      end
    end
  end
`else
  // Lowest-index valid port wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (!any_valid && ireqs[k].valid) begin
        winner    = SEL_W'(k);
        any_valid = 1'b1;
      end
    end
  end
`endif

  // Grant FSM: sel is frozen for the whole transaction, released on ready&last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
      last_grant <= SEL_W'(NUM_PORTS - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state <= BUSY;
            sel   <= winner;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
            last_grant <= winner;
`endif
          end
        end
        BUSY: begin
          if (oresp.ready && oresp.last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational routing keeps request and response paths at zero added latency.
  always_comb begin
    oreq = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      iresps[i] = '0;
    end
    if (state == BUSY) begin
      oreq = ireqs[sel];
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (sel == SEL_W'(i)) begin
          iresps[i] = oresp;
        end
      end
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: randomized and directed stimulus for cbus_arbiter with a transaction-level
// grant model feeding a scoreboard queue that a negedge monitor drains.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int unsigned NP = 3;

  typedef struct packed {
    logic [1:0] port;
    cbus_req_t  req;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  cbus_req_t  ireqs  [NP];
  cbus_resp_t iresps [NP];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  cbus_arbiter #(.NUM_PORTS(NP)) dut (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] want);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Per-master pending requests; the head is presented until its last beat is seen.
  cbus_req_t mq [NP][$];
  exp_t      expq[$];

  // Reference model: a free arbiter picks one valid master per the priority rule and
  // stays busy until that master has received len+1 ready beats.
  bit m_busy;
  int m_beats, m_len, m_ptr, w;

  initial begin : model
    m_busy = 1'b0;
    m_ptr  = NP - 1;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_busy = 1'b0;
        m_ptr  = NP - 1;
      end else if (m_busy) begin
        if (oresp.ready) begin
          m_beats++;
          if (m_beats == m_len + 1) m_busy = 1'b0;
        end
      end else begin
        w = -1;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
        for (int k = 1; k <= NP; k++) begin
          if (w < 0 && ireqs[(m_ptr + k) % NP].valid) w = (m_ptr + k) % NP;
        end
`else
        for (int k = 0; k < NP; k++) begin
          if (w < 0 && ireqs[k].valid) w = k;
        end
`endif
        if (w >= 0) begin
          exp_t e;
          e.port = 2'(w);
          e.req  = ireqs[w];
          expq.push_back(e);
          m_busy  = 1'b1;
          m_beats = 0;
          m_len   = int'(ireqs[w].len);
          m_ptr   = w;
        end
      end
    end
  end

  // Masters and downstream RAM: inputs change #1/#2 after the edge, outputs sampled at negedge.
  bit done [NP];
  bit beat_fire, beat_last;
  int ram_cnt;

  initial begin : drv
    for (int i = 0; i < NP; i++) ireqs[i] = '0;
    oresp   = '0;
    ram_cnt = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) done[i] = iresps[i].ready && iresps[i].last;
      beat_fire = oreq.valid && oresp.ready;
      beat_last = oresp.last;
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (done[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        ireqs[i] = (mq[i].size() > 0) ? mq[i][0] : '0;
      end
      #1;
      if (reset) ram_cnt = 0;
      else if (beat_fire) ram_cnt = beat_last ? 0 : ram_cnt + 1;
      oresp = '0;
      if (oreq.valid && !reset && $urandom_range(0, 9) < 7) begin
        oresp.ready = 1'b1;
        oresp.last  = (ram_cnt == int'(oreq.len));
        oresp.data  = {oreq.addr, 32'(ram_cnt) ^ 32'hC0DE_0000};
      end
    end
  end

  // Monitor: pops an expectation when a grant appears, then checks routing every beat.
  bit         act;
  int         cur, mbeats, mlen;
  bit         z;
  exp_t       me;
  cbus_resp_t want;

  initial begin : monitor
    act = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        z = (oreq == '0);
        for (int j = 0; j < NP; j++) if (iresps[j] != '0) z = 1'b0;
        chk(z, "reset_outputs_zero", 128'(oreq), 128'(0));
        expq.delete();
        act = 1'b0;
      end else begin
        if (!act) begin
          if (expq.size() > 0) begin
            me = expq.pop_front();
            chk(oreq == me.req, "grant_req", 128'(oreq), 128'(me.req));
            act    = 1'b1;
            cur    = int'(me.port);
            mbeats = 0;
            mlen   = int'(me.req.len);
          end else begin
            z = (oreq == '0);
            for (int j = 0; j < NP; j++) if (iresps[j] != '0) z = 1'b0;
            chk(z, "idle_outputs_zero", 128'(oreq), 128'(0));
          end
        end
        if (act) begin
          chk(oreq == ireqs[cur], "forward_req", 128'(oreq), 128'(ireqs[cur]));
          for (int j = 0; j < NP; j++) begin
            if (j == cur) want = oresp;
            else want = '0;
            chk(iresps[j] == want, $sformatf("resp_port%0d", j), 128'(iresps[j]), 128'(want));
          end
          if (oresp.ready) mbeats++;
          if (oresp.ready && oresp.last) begin
            chk(mbeats == mlen + 1, "beat_count", 128'(mbeats), 128'(mlen + 1));
            act = 1'b0;
          end
        end
      end
    end
  end

  function automatic cbus_req_t mk(input bit wr, input logic [2:0] size, input logic [31:0] addr,
                                   input logic [7:0] len, input logic [63:0] data, input logic [7:0] strb);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = size;
    r.addr     = addr;
    r.len      = len;
    r.data     = data;
    r.strobe   = strb;
    r.burst    = 2'd1;
    return r;
  endfunction

  function automatic cbus_req_t rnd(input int p);
    return mk(1'($urandom), 3'($urandom_range(0, 3)), {2'(p), 30'($urandom)},
              8'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom));
  endfunction

  task automatic wait_idle(input int limit);
    int  n;
    bit  empty;
    n = 0;
    forever begin
      empty = (expq.size() == 0) && !m_busy;
      for (int i = 0; i < NP; i++) if (mq[i].size() > 0) empty = 1'b0;
      if (empty || n >= limit) break;
      @(posedge clk);
      #2;
      n++;
    end
    chk(n < limit, "drain_timeout", 128'(n), 128'(limit));
  endtask

  int p, n;

  initial begin : stim
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single 4-beat read on port 0.
    mq[0].push_back(mk(1'b0, 3'd3, 32'h8000_0000, 8'd3, 64'd0, 8'h00));
    wait_idle(200);

    // Contention: port 0 back-to-back against port 1.
    for (int k = 0; k < 3; k++) mq[0].push_back(mk(1'b0, 3'd3, 32'h0000_1000 + 32'(k * 8), 8'd1, 64'd0, 8'h00));
    mq[1].push_back(mk(1'b0, 3'd3, 32'h4000_0000, 8'd1, 64'd0, 8'h00));
    wait_idle(300);

    // Single-beat contention including the port 1 write.
    for (int k = 0; k < 3; k++) mq[0].push_back(mk(1'b0, 3'd3, 32'h0000_2000 + 32'(k * 8), 8'd0, 64'd0, 8'h00));
    mq[1].push_back(mk(1'b1, 3'd3, 32'h2333_3000, 8'd0, 64'h233, 8'hFF));
    mq[1].push_back(mk(1'b1, 3'd3, 32'h2333_3008, 8'd0, 64'h234, 8'hFF));
    wait_idle(300);

    // Port 1 long burst with port 0 arriving mid-burst.
    mq[1].push_back(mk(1'b0, 3'd3, 32'h5000_0000, 8'd7, 64'd0, 8'h00));
    repeat (4) @(posedge clk);
    #2 mq[0].push_back(mk(1'b0, 3'd3, 32'h0000_3000, 8'd1, 64'd0, 8'h00));
    wait_idle(300);

    // Reset on beat 2 of a 4-beat read, then a fresh port 1 request.
    mq[0].push_back(mk(1'b0, 3'd3, 32'h8000_0100, 8'd3, 64'd0, 8'h00));
    n = 0;
    while (n < 200 && !(m_busy && m_beats == 1)) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(n < 200, "beat2_timeout", 128'(n), 128'(200));
    reset = 1'b1;
    mq[0].delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mq[1].push_back(mk(1'b0, 3'd3, 32'h6000_0000, 8'd2, 64'd0, 8'h00));
    wait_idle(300);

    // Random traffic.
    repeat (1500) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 7) == 0) begin
        p = $urandom_range(0, NP - 1);
        if (mq[p].size() < 3) mq[p].push_back(rnd(p));
      end
    end
    wait_idle(5000);
    repeat (3) @(posedge clk);
    chk(expq.size() == 0 && !act, "scoreboard_empty", 128'(expq.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
